// File: rtl/main_register_pkg.sv
// ============================================================================
//  Module      : main_register_pkg
//  Description : Shared default widths and the register-word type used by
//                main_register and its users.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package main_register_pkg;

    localparam int c_DEFAULT_DATA_W = 8;
    localparam int c_DEFAULT_ADDR_W = 2;

    typedef logic [c_DEFAULT_DATA_W-1:0] word_t;

endpackage : main_register_pkg

`default_nettype wire

// File: rtl/main_register.sv
// ============================================================================
//  Module      : main_register
//  Description : 2**ADDR_W x DATA_W register file, one write port sharing the
//                port-A address, two combinational read ports, async reset.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module main_register
    import main_register_pkg::*;
#(
    parameter int DATA_W = c_DEFAULT_DATA_W,
    parameter int ADDR_W = c_DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] raAddress,
    input  logic [ADDR_W-1:0] rbAddress,
    output logic [DATA_W-1:0] regA,
    output logic [DATA_W-1:0] regB,
    input  logic              regWrite,
    input  logic [DATA_W-1:0] dataIn
);

    localparam int c_NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_regFile [c_NUM_REGS];

    // Reset wins over a coincident write; register 0 is an ordinary register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < c_NUM_REGS; i++) begin
                r_regFile[i] <= '0;
            end
        end else if (regWrite) begin
            r_regFile[raAddress] <= dataIn;
        end
    end

    // Reads come only from stored contents, so a write is visible after the edge.
    assign regA = r_regFile[raAddress];
    assign regB = r_regFile[rbAddress];

endmodule : main_register

`default_nettype wire

// File: tb/tb_main_register.sv
// ============================================================================
//  Module      : tb_main_register
//  Description : Directed scoreboard bench for main_register.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_main_register;
    import main_register_pkg::*;

    localparam int c_DATA_W = c_DEFAULT_DATA_W;
    localparam int c_ADDR_W = c_DEFAULT_ADDR_W;

    typedef struct {
        string tag;
        word_t expA;
        word_t expB;
    } exp_t;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic [c_ADDR_W-1:0] raAddress = '0;
    logic [c_ADDR_W-1:0] rbAddress = '0;
    logic [c_DATA_W-1:0] regA;
    logic [c_DATA_W-1:0] regB;
    logic                regWrite = 1'b0;
    logic [c_DATA_W-1:0] dataIn = '0;

    exp_t expQ[$];
    event sampleEv;
    int   passCount = 0;
    int   totalCount = 0;

    main_register #(
        .DATA_W (c_DATA_W),
        .ADDR_W (c_ADDR_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .raAddress (raAddress),
        .rbAddress (rbAddress),
        .regA      (regA),
        .regB      (regB),
        .regWrite  (regWrite),
        .dataIn    (dataIn)
    );

    always #5 clk = ~clk;

    // Monitor: pops expectations whenever the stimulus presents a sample point.
    initial begin
        forever begin
            @(sampleEv);
            while (expQ.size() > 0) begin
                exp_t e;
                e = expQ.pop_front();
                totalCount++;
                if (regA === e.expA && regB === e.expB) begin
                    passCount++;
                end else begin
                    $display("FAIL %s: got regA=%0d regB=%0d, expected regA=%0d regB=%0d",
                             e.tag, regA, regB, e.expA, e.expB);
                end
            end
        end
    end

    task automatic expectRead(input string tag, input word_t a, input word_t b);
        exp_t e;
        e.tag  = tag;
        e.expA = a;
        e.expB = b;
        expQ.push_back(e);
        ->sampleEv;
        #1;
    endtask

    // Advance past the next rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        // Reset applied with a pending write of 25.
        regWrite = 1'b1;
        dataIn   = 8'd25;
        #1 reset = 1'b1;
        #1;
        expectRead("reset_async", 8'd0, 8'd0);
        tick();
        expectRead("reset_blocks_write", 8'd0, 8'd0);

        // Basic write of 25 to register 0.
        @(negedge clk);
        reset     = 1'b0;
        raAddress = 2'd0;
        dataIn    = 8'd25;
        regWrite  = 1'b1;
        tick();
        regWrite  = 1'b0;
        raAddress = 2'd1;
        rbAddress = 2'd0;
        #1;
        expectRead("write_reg0", 8'd0, 8'd25);

        // Second write: 100 to register 1, no bypass before the edge.
        regWrite = 1'b1;
        dataIn   = 8'd100;
        #1;
        expectRead("no_bypass_reg1", 8'd0, 8'd25);
        tick();
        regWrite = 1'b0;
        #1;
        expectRead("write_reg1", 8'd100, 8'd25);

        // Write 45 to register 2, then hold regWrite low with 99 on dataIn.
        raAddress = 2'd2;
        dataIn    = 8'd45;
        regWrite  = 1'b1;
        tick();
        regWrite  = 1'b0;
        dataIn    = 8'd99;
        repeat (3) begin
            tick();
            raAddress = raAddress + 2'd1;
        end
        raAddress = 2'd2;
        rbAddress = 2'd2;
        #1;
        expectRead("wen_low_reg2", 8'd45, 8'd45);
        raAddress = 2'd0;
        rbAddress = 2'd1;
        #1;
        expectRead("wen_low_reg0_1", 8'd25, 8'd100);
        raAddress = 2'd3;
        rbAddress = 2'd3;
        #1;
        expectRead("wen_low_reg3", 8'd0, 8'd0);

        // Same address on both ports, write 77 to register 3.
        regWrite = 1'b1;
        dataIn   = 8'd77;
        #1;
        expectRead("same_addr_before", 8'd0, 8'd0);
        tick();
        expectRead("same_addr_after", 8'd77, 8'd77);

        // Back-to-back writes to register 3 keep the last value.
        dataIn = 8'd78;
        tick();
        dataIn = 8'd79;
        tick();
        regWrite = 1'b0;
        expectRead("consecutive_writes", 8'd79, 8'd79);

        // Asynchronous reset between edges.
        rbAddress = 2'd1;
        #1;
        expectRead("pre_async_reset", 8'd79, 8'd100);
        reset = 1'b1;
        #1;
        expectRead("async_reset_mid_cycle", 8'd0, 8'd0);

        // Write attempted while reset is held.
        raAddress = 2'd1;
        rbAddress = 2'd2;
        regWrite  = 1'b1;
        dataIn    = 8'd55;
        tick();
        expectRead("write_during_reset", 8'd0, 8'd0);

        // First write after release lands on the first edge with reset low.
        reset = 1'b0;
        tick();
        regWrite  = 1'b0;
        rbAddress = 2'd0;
        #1;
        expectRead("first_write_after_reset", 8'd55, 8'd0);
        raAddress = 2'd3;
        rbAddress = 2'd2;
        #1;
        expectRead("contents_discarded", 8'd0, 8'd0);

        #2;
        ->sampleEv;
        #2;
        if (expQ.size() != 0) begin
            totalCount++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", expQ.size());
        end
        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule : tb_main_register

`default_nettype wire
